// File: rtl/tpm_cmd_buffer.sv
// TPM command buffer: gathers TPM_DATA_FIFO bytes, parses commandSize, then streams the command to the core.
// TPM_STS.expect is exported as sts_expect because "expect" is a reserved SystemVerilog keyword.
module tpm_cmd_buffer #(
  parameter int DEPTH = 1024,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [7:0]  wr_byte,
  input  logic        go,
  input  logic        cmd_ready,
  input  logic        cmd_take,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        cmd_last,
  output logic [31:0] cmd_size,
  output logic        sts_expect,
  output logic [15:0] burst_count,
  output logic        err,
  output logic [1:0]  state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(DEPTH);
  localparam logic [15:0]      DEPTH_BURST = 16'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RECEIVE  = 2'd1,
    S_COMPLETE = 2'd2,
    S_EXECUTE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]      cmd_size_q, cmd_size_d;
  logic             expect_q, expect_d;
  logic             err_q, err_d;
  logic             hdr_bad_q, hdr_bad_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_last_q, cmd_last_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d;
  logic [15:0]      burst_q, burst_d;

  logic [7:0]       mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [CNT_W-1:0] new_count;
  logic [31:0]      size_shift;

  assign mem_addr   = count_q[AW-1:0];
  assign new_count  = count_q + CNT_W'(1);
  assign size_shift = {cmd_size_q[23:0], wr_byte};

  // Handshake: cmd_byte/cmd_last are valid while cmd_valid=1 and held until a
  // cycle with cmd_take=1; the transfer completes on that edge and the next
  // cycle is a fetch cycle with cmd_valid=0.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    cmd_size_d  = cmd_size_q;
    expect_d    = expect_q;
    err_d       = err_q;
    hdr_bad_d   = hdr_bad_q;
    cmd_valid_d = cmd_valid_q;
    cmd_last_d  = cmd_last_q;
    cmd_byte_d  = cmd_byte_q;
    burst_d     = burst_q;
    mem_we      = 1'b0;

    if (cmd_ready) begin
      state_d     = S_IDLE;
      count_d     = '0;
      rd_ptr_d    = '0;
      cmd_size_d  = '0;
      expect_d    = 1'b0;
      err_d       = 1'b0;
      hdr_bad_d   = 1'b0;
      cmd_valid_d = 1'b0;
      cmd_last_d  = 1'b0;
      burst_d     = DEPTH_BURST;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_valid) begin
            mem_we   = 1'b1;
            count_d  = new_count;
            expect_d = 1'b1;
            state_d  = S_RECEIVE;
            burst_d  = 16'(DEPTH_CNT - new_count);
          end
        end
        S_RECEIVE: begin
          if (wr_valid) begin
            mem_we  = 1'b1;
            count_d = new_count;
            burst_d = 16'(DEPTH_CNT - new_count);
            if (count_q >= CNT_W'(2) && count_q <= CNT_W'(5)) cmd_size_d = size_shift;
            // Header just finished: size_shift holds the complete commandSize.
            if (new_count == CNT_W'(6)) begin
              if (size_shift < 32'd10 || size_shift > 32'(DEPTH)) begin
                err_d     = 1'b1;
                hdr_bad_d = 1'b1;
                expect_d  = 1'b0;
                state_d   = S_COMPLETE;
                burst_d   = '0;
              end
            end else if (new_count > CNT_W'(6) && 32'(new_count) == cmd_size_q) begin
              expect_d = 1'b0;
              state_d  = S_COMPLETE;
              burst_d  = '0;
            end
          end
        end
        S_COMPLETE: begin
          if (hdr_bad_q) begin
            state_d = S_COMPLETE;
          end else if (go) begin
            state_d  = S_EXECUTE;
            rd_ptr_d = '0;
          end else if (wr_valid) begin
            err_d = 1'b1;
          end
        end
        S_EXECUTE: begin
          if (wr_valid) err_d = 1'b1;
          if (!cmd_valid_q) begin
            cmd_valid_d = 1'b1;
            cmd_byte_d  = mem_q[rd_ptr_q[AW-1:0]];
            cmd_last_d  = (32'(rd_ptr_q) == cmd_size_q - 32'd1);
          end else if (cmd_take) begin
            cmd_valid_d = 1'b0;
            cmd_last_d  = 1'b0;
            rd_ptr_d    = rd_ptr_q + CNT_W'(1);
            if (cmd_last_q) begin
              state_d    = S_IDLE;
              count_d    = '0;
              rd_ptr_d   = '0;
              cmd_size_d = '0;
              burst_d    = DEPTH_BURST;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      cmd_size_q  <= '0;
      expect_q    <= 1'b0;
      err_q       <= 1'b0;
      hdr_bad_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_last_q  <= 1'b0;
      cmd_byte_q  <= '0;
      burst_q     <= DEPTH_BURST;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      cmd_size_q  <= cmd_size_d;
      expect_q    <= expect_d;
      err_q       <= err_d;
      hdr_bad_q   <= hdr_bad_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_last_q  <= cmd_last_d;
      cmd_byte_q  <= cmd_byte_d;
      burst_q     <= burst_d;
    end
  end

  // Buffer contents survive reset and abort; only the pointers are cleared.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_addr] <= wr_byte;
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_byte    = cmd_byte_q;
  assign cmd_last    = cmd_last_q;
  assign cmd_size    = cmd_size_q;
  assign sts_expect  = expect_q;
  assign burst_count = burst_q;
  assign err         = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_tpm_cmd_buffer.sv
// Directed bench for tpm_cmd_buffer: command collection, header validation, abort, streaming, reset.
module tb_tpm_cmd_buffer;

  logic        clock;
  logic        reset;
  logic        wr_valid;
  logic [7:0]  wr_byte;
  logic        go;
  logic        cmd_ready;
  logic        cmd_take;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        cmd_last;
  logic [31:0] cmd_size;
  logic        sts_expect;
  logic [15:0] burst_count;
  logic        err;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  int         exec_cycles;
  int         exec_timeout;
  int         unstable;

  tpm_cmd_buffer dut (
    .clock(clock), .reset(reset), .wr_valid(wr_valid), .wr_byte(wr_byte),
    .go(go), .cmd_ready(cmd_ready), .cmd_take(cmd_take),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .cmd_last(cmd_last),
    .cmd_size(cmd_size), .sts_expect(sts_expect), .burst_count(burst_count),
    .err(err), .state(state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_valid = 1'b1;
    wr_byte  = b;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic write_seq(input int n);
    for (int i = 0; i < n; i++) write_byte(exp_q[i]);
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic pulse_ready();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  // Collects streamed bytes into got_q; hold=1 keeps cmd_take high throughout,
  // hold=0 waits one extra cycle before each take and records byte instability.
  task automatic run_execute(input int budget, input bit hold);
    bit done;
    logic [7:0] held_b;
    logic       held_l;
    got_q.delete();
    got_last_q.delete();
    exec_cycles = 0;
    unstable = 0;
    done = 1'b0;
    cmd_take = hold;
    while (!done && exec_cycles < budget) begin
      if (cmd_valid) begin
        got_q.push_back(cmd_byte);
        got_last_q.push_back(cmd_last);
        held_b = cmd_byte;
        held_l = cmd_last;
        if (!hold) begin
          tick();
          exec_cycles++;
          if (cmd_byte !== held_b || cmd_last !== held_l || cmd_valid !== 1'b1) unstable++;
        end
        cmd_take = 1'b1;
        tick();
        exec_cycles++;
        if (!hold) cmd_take = 1'b0;
        if (held_l) done = 1'b1;
      end else begin
        tick();
        exec_cycles++;
      end
    end
    cmd_take = 1'b0;
    exec_timeout = done ? 0 : 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%0b want=0", cmd_valid); end
    total++; if (cmd_last !== 1'b0) begin bad++; $display("FAIL reset_cmd_last got=%0b want=0", cmd_last); end
    total++; if (sts_expect !== 1'b0) begin bad++; $display("FAIL reset_expect got=%0b want=0", sts_expect); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b want=0", err); end
    total++; if (cmd_size !== 32'd0) begin bad++; $display("FAIL reset_cmd_size got=%0d want=0", cmd_size); end
    total++; if (cmd_byte !== 8'h00) begin bad++; $display("FAIL reset_cmd_byte got=%0h want=0", cmd_byte); end
    total++; if (burst_count !== 16'd1024) begin bad++; $display("FAIL reset_burst got=%0d want=1024", burst_count); end
  endtask

  task automatic test_normal_cmd();
    exp_q = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
    write_byte(exp_q[0]);
    total++; if (sts_expect !== 1'b1) begin bad++; $display("FAIL t1_expect_first got=%0b want=1", sts_expect); end
    total++; if (burst_count !== 16'd1023) begin bad++; $display("FAIL t1_burst_first got=%0d want=1023", burst_count); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL t1_state_recv got=%0d want=1", state); end
    for (int i = 1; i < 11; i++) write_byte(exp_q[i]);
    total++; if (sts_expect !== 1'b1) begin bad++; $display("FAIL t1_expect_11 got=%0b want=1", sts_expect); end
    total++; if (burst_count !== 16'd1013) begin bad++; $display("FAIL t1_burst_11 got=%0d want=1013", burst_count); end
    total++; if (cmd_size !== 32'd12) begin bad++; $display("FAIL t1_cmd_size got=%0d want=12", cmd_size); end
    write_byte(exp_q[11]);
    total++; if (sts_expect !== 1'b0) begin bad++; $display("FAIL t1_expect_12 got=%0b want=0", sts_expect); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t1_state_complete got=%0d want=2", state); end
    total++; if (burst_count !== 16'd0) begin bad++; $display("FAIL t1_burst_complete got=%0d want=0", burst_count); end
    pulse_go();
    total++; if (state !== 2'd3) begin bad++; $display("FAIL t1_state_exec got=%0d want=3", state); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL t1_fetch_valid got=%0b want=0", cmd_valid); end
    run_execute(100, 1'b0);
    total++; if (exec_timeout !== 0) begin bad++; $display("FAIL t1_timeout got=%0d want=0", exec_timeout); end
    total++; if (got_q.size() !== 12) begin bad++; $display("FAIL t1_count got=%0d want=12", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 12; i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL t1_byte%0d got=%0h want=%0h", i, got_q[i], exp_q[i]); end
      total++; if (got_last_q[i] !== (i == 11)) begin bad++; $display("FAIL t1_last%0d got=%0b want=%0b", i, got_last_q[i], (i == 11)); end
    end
    total++; if (unstable !== 0) begin bad++; $display("FAIL t1_stable got=%0d want=0", unstable); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t1_state_idle got=%0d want=0", state); end
    total++; if (burst_count !== 16'd1024) begin bad++; $display("FAIL t1_burst_idle got=%0d want=1024", burst_count); end
    total++; if (cmd_size !== 32'd0) begin bad++; $display("FAIL t1_size_cleared got=%0d want=0", cmd_size); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL t1_err got=%0b want=0", err); end
  endtask

  task automatic test_bad_size();
    int seen_valid;
    exp_q = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h04};
    write_seq(5);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL t2_err_early got=%0b want=0", err); end
    write_byte(exp_q[5]);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL t2_err got=%0b want=1", err); end
    total++; if (sts_expect !== 1'b0) begin bad++; $display("FAIL t2_expect got=%0b want=0", sts_expect); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t2_state got=%0d want=2", state); end
    pulse_go();
    seen_valid = 0;
    for (int i = 0; i < 6; i++) begin
      if (cmd_valid === 1'b1 || state !== 2'd2) seen_valid++;
      tick();
    end
    total++; if (seen_valid !== 0) begin bad++; $display("FAIL t2_go_ignored got=%0d want=0", seen_valid); end
    pulse_ready();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL t2_err_cleared got=%0b want=0", err); end
    total++; if (burst_count !== 16'd1024) begin bad++; $display("FAIL t2_burst got=%0d want=1024", burst_count); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t2_state_idle got=%0d want=0", state); end
  endtask

  task automatic test_overrun();
    exp_q = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h7E};
    write_seq(10);
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t3_state_complete got=%0d want=2", state); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL t3_err_before got=%0b want=0", err); end
    write_byte(8'hEE);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL t3_err_extra got=%0b want=1", err); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t3_state_after_extra got=%0d want=2", state); end
    pulse_go();
    run_execute(100, 1'b0);
    total++; if (exec_timeout !== 0) begin bad++; $display("FAIL t3_timeout got=%0d want=0", exec_timeout); end
    total++; if (got_q.size() !== 10) begin bad++; $display("FAIL t3_count got=%0d want=10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL t3_byte%0d got=%0h want=%0h", i, got_q[i], exp_q[i]); end
    end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL t3_err_kept got=%0b want=1", err); end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t3_state_idle got=%0d want=0", state); end
    pulse_ready();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL t3_err_cleared got=%0b want=0", err); end
  endtask

  task automatic test_abort();
    exp_q = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h55};
    write_seq(7);
    total++; if (burst_count !== 16'd1017) begin bad++; $display("FAIL t4_burst_7 got=%0d want=1017", burst_count); end
    total++; if (state !== 2'd1) begin bad++; $display("FAIL t4_state_recv got=%0d want=1", state); end
    pulse_ready();
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t4_state_idle got=%0d want=0", state); end
    total++; if (sts_expect !== 1'b0) begin bad++; $display("FAIL t4_expect got=%0b want=0", sts_expect); end
    total++; if (burst_count !== 16'd1024) begin bad++; $display("FAIL t4_burst got=%0d want=1024", burst_count); end
    total++; if (cmd_size !== 32'd0) begin bad++; $display("FAIL t4_size got=%0d want=0", cmd_size); end
    exp_q = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h11, 8'h22, 8'h33, 8'h44};
    write_seq(10);
    total++; if (cmd_size !== 32'd10) begin bad++; $display("FAIL t4_new_size got=%0d want=10", cmd_size); end
    total++; if (state !== 2'd2) begin bad++; $display("FAIL t4_new_complete got=%0d want=2", state); end
    pulse_go();
    run_execute(100, 1'b0);
    total++; if (got_q.size() !== 10) begin bad++; $display("FAIL t4_count got=%0d want=10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL t4_byte%0d got=%0h want=%0h", i, got_q[i], exp_q[i]); end
    end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t4_state_end got=%0d want=0", state); end
  endtask

  task automatic test_back_to_back();
    exp_q = '{8'h80, 8'h02, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    write_seq(10);
    pulse_go();
    run_execute(60, 1'b1);
    total++; if (exec_timeout !== 0) begin bad++; $display("FAIL t5_timeout got=%0d want=0", exec_timeout); end
    total++; if (exec_cycles !== 20) begin bad++; $display("FAIL t5_cycles got=%0d want=20", exec_cycles); end
    total++; if (got_q.size() !== 10) begin bad++; $display("FAIL t5_count got=%0d want=10", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 10; i++) begin
      total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL t5_byte%0d got=%0h want=%0h", i, got_q[i], exp_q[i]); end
    end
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t5_state got=%0d want=0", state); end
    total++; if (burst_count !== 16'd1024) begin bad++; $display("FAIL t5_burst got=%0d want=1024", burst_count); end
  endtask

  task automatic test_reset_mid_exec();
    int seen;
    int cyc;
    int late_valid;
    exp_q = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h9A, 8'h00, 8'h01, 8'h44, 8'h00, 8'h00};
    write_seq(12);
    pulse_go();
    seen = 0;
    cyc = 0;
    while (cyc < 40 && !(cmd_valid === 1'b1 && seen == 2)) begin
      if (cmd_valid === 1'b1) begin
        cmd_take = 1'b1;
        tick();
        cmd_take = 1'b0;
        seen++;
      end else begin
        tick();
      end
      cyc++;
    end
    total++; if (!(cmd_valid === 1'b1 && seen == 2)) begin bad++; $display("FAIL t6_reach_third got=%0d want=2", seen); end
    total++; if (cmd_byte !== 8'h00) begin bad++; $display("FAIL t6_third_byte got=%0h want=0", cmd_byte); end
    reset = 1'b1;
    cmd_take = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (state !== 2'd0) begin bad++; $display("FAIL t6_state got=%0d want=0", state); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL t6_valid got=%0b want=0", cmd_valid); end
    total++; if (cmd_last !== 1'b0) begin bad++; $display("FAIL t6_last got=%0b want=0", cmd_last); end
    total++; if (cmd_size !== 32'd0) begin bad++; $display("FAIL t6_size got=%0d want=0", cmd_size); end
    total++; if (cmd_byte !== 8'h00) begin bad++; $display("FAIL t6_byte got=%0h want=0", cmd_byte); end
    total++; if (burst_count !== 16'd1024) begin bad++; $display("FAIL t6_burst got=%0d want=1024", burst_count); end
    total++; if (sts_expect !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL t6_flags got=%0b%0b want=00", sts_expect, err); end
    late_valid = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (cmd_valid !== 1'b0 || state !== 2'd0) late_valid++;
    end
    cmd_take = 1'b0;
    total++; if (late_valid !== 0) begin bad++; $display("FAIL t6_take_after_reset got=%0d want=0", late_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    wr_valid = 1'b0;
    wr_byte = 8'h00;
    go = 1'b0;
    cmd_ready = 1'b0;
    cmd_take = 1'b0;
    test_reset();
    test_normal_cmd();
    test_bad_size();
    test_overrun();
    test_abort();
    test_back_to_back();
    test_reset_mid_exec();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
